// File: rtl/data_mem_unit.sv
// data_mem_unit: word RAM with registered fetch port, handshaked load/store port and MMIO window.
// Optional feature: define DMU_CYCLE_CNT_EN for a free-running cycle counter at MMIO offset 0xF0.
`ifndef LDST_WID
`define LDST_WID 3
`define LW_OP  3'd0
`define LH_OP  3'd1
`define LHU_OP 3'd2
`define LB_OP  3'd3
`define LBU_OP 3'd4
`define SW_OP  3'd5
`define SH_OP  3'd6
`define SB_OP  3'd7
`endif

module data_mem_unit #(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [15:0] MMIO_HI = 16'hffff,
    parameter int unsigned SW_W    = 8,
    parameter int unsigned NUM_OUT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            if_addr,
    output logic [31:0]            if_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [`LDST_WID-1:0]   ldst,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rdata,
    output logic                   fault,
    input  logic [SW_W-1:0]        switches,
    output logic [NUM_OUT*32-1:0]  out_regs
);
    typedef logic [`LDST_WID-1:0] op_t;
    localparam op_t OP_LW = `LW_OP, OP_LH = `LH_OP, OP_LHU = `LHU_OP, OP_LB = `LB_OP,
                    OP_LBU = `LBU_OP, OP_SW = `SW_OP, OP_SH = `SH_OP, OP_SB = `SB_OP;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_IO, S_RESP} state_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] if_data_q, ram_rd_q;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic [31:0] out_q [NUM_OUT];
    logic [31:0] mem [2**ADDR_W];
    logic        ram_we, out_we, cnt_clr;
    logic [31:0] io_word;
    logic [7:0]  io_off;
    logic        io_win;
    logic        unused_bits;

    function automatic logic misaligned(input op_t op, input logic [1:0] a);
        return ((op == OP_LW || op == OP_SW) && a != 2'b00) ||
               ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]);
    endfunction

    function automatic logic [31:0] fmt_load(input op_t op, input logic [1:0] lane, input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? w[31:16] : w[15:0];
        b = 8'(w >> {lane, 3'b000});
        case (op)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input op_t op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [31:0] wd);
        if (op == OP_SH)
            return lane[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
        case (lane)
            2'd0:    return {w[31:8], wd[7:0]};
            2'd1:    return {w[31:16], wd[7:0], w[7:0]};
            2'd2:    return {w[31:24], wd[7:0], w[15:0]};
            default: return {wd[7:0], w[23:0]};
        endcase
    endfunction

    assign io_off = addr_q[7:0];
    assign io_win = (addr_q[15:8] == 8'hff);

`ifdef DMU_CYCLE_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else              cnt_q <= cnt_q + 32'd1;
    end
`endif

    always_comb begin
        io_word = '0;
        if (io_win) begin
            if (io_off == 8'h00) io_word = 32'(sw_sync_q);
            for (int unsigned i = 0; i < NUM_OUT; i++)
                if (io_off == 8'(4 + 4 * i)) io_word = out_q[i];
`ifdef DMU_CYCLE_CNT_EN
            if (io_off == 8'hF0) io_word = cnt_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        ram_we  = 1'b0;
        out_we  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                op_d    = ldst;
                addr_d  = addr;
                wdata_d = wdata;
                if (misaligned(ldst, addr[1:0])) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (addr[31:16] == MMIO_HI) state_d = S_IO;
                else if (ldst == OP_SW)              state_d = S_WR;
                else                                 state_d = S_RD;
            end
            // Sub-word stores reuse wdata_q to carry the merged word into WR.
            S_RD: if (op_q == OP_SH || op_q == OP_SB) begin
                wdata_d = merge(op_q, addr_q[1:0], ram_rd_q, wdata_q);
                state_d = S_WR;
            end else begin
                rdata_d = fmt_load(op_q, addr_q[1:0], ram_rd_q);
                fault_d = 1'b0;
                state_d = S_RESP;
            end
            S_WR: begin
                ram_we  = 1'b1;
                rdata_d = '0;
                fault_d = 1'b0;
                state_d = S_RESP;
            end
            S_IO: begin
                state_d = S_RESP;
                rdata_d = '0;
                fault_d = 1'b0;
                if (op_q == OP_SH || op_q == OP_SB) begin
                    fault_d = 1'b1;
                end else if (op_q == OP_SW) begin
                    out_we  = io_win;
                    cnt_clr = io_win && (io_off == 8'hF0);
                end else begin
                    rdata_d = fmt_load(op_q, addr_q[1:0], io_word);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LW;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            if_data_q <= '0;
            ram_rd_q  <= '0;
            for (int unsigned i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            if_data_q <= mem[if_addr[ADDR_W+1:2]];
            if (state_q == S_IDLE) ram_rd_q <= mem[addr[ADDR_W+1:2]];
            for (int unsigned i = 0; i < NUM_OUT; i++)
                if (out_we && io_off == 8'(4 + 4 * i)) out_q[i] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[addr_q[ADDR_W+1:2]] <= wdata_q;
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_regs[32*g +: 32] = out_q[g];
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rdata       = rdata_q;
    assign fault       = fault_q;
    assign if_data     = if_data_q;
    assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], addr_q[31:16]};

endmodule
